uart_byte_receiver: RTL and testbench
=====================================

// Module: uart_byte_receiver
// PURPOSE
// - Front end of the UART programming path. Deserialises the async rx line (8N1, LSB first)
//   into bytes and buffers them in a small show-ahead FIFO.
// - The downstream instruction RAM writer pops one byte per rd_en, including the '$' (0x24) separators.
// - Replaces change-detection on a raw byte bus with an explicit valid/rd_en handshake.
// PARAMETERS
// - CLK_FREQ    50000000  system clock frequency, Hz
// - BAUD        115200    line rate, bit/s
// - DATA_WIDTH  8         bits per character
// - FIFO_DEPTH  4         byte buffer entries, power of 2, >=2
// PORTS
// - clk         in   1                      system clock, all logic on posedge
// - rst         in   1                      synchronous, active-high reset
// - rx          in   1                      async serial line, idle high
// - rd_en       in   1                      pop head byte; ignored when data_valid=0
// - data_out    out  DATA_WIDTH             FIFO head byte; don't-care when data_valid=0
// - data_valid  out  1                      FIFO not empty
// - fifo_count  out  $clog2(FIFO_DEPTH)+1   bytes buffered
// - frame_err   out  1                      1-clk pulse: stop bit sampled low
// - parity_err  out  1                      1-clk pulse: parity mismatch (see CONFIGURATION)
// - overrun     out  1                      sticky: byte dropped because FIFO full
// BEHAVIOUR
// - Reset:
//   - All outputs 0; FIFO emptied; FSM=IDLE; rx synchroniser preset to 1.
//   - rst mid-frame aborts the frame; no partial byte is pushed.
// - Input synchroniser: rx passes through a 2-FF synchroniser; all logic uses the synced value.
// - Oversample tick:
//   - DIV = CLK_FREQ/(16*BAUD), integer floor (50 MHz/115200 -> 27).
//   - Counter 0..DIV-1; tick = 1 clk when the counter wraps.
//   - Counter reset to 0 on entering START.
// - Sample count: a 4-bit tick counter per bit; each bit is sampled at tick 7 (mid-bit).
// - FSM:
//   - IDLE: synced rx=0 -> START.
//   - START: at mid-bit, rx=1 -> IDLE (glitch rejected, no error); rx=0 -> DATA.
//   - DATA: DATA_WIDTH bits shifted in LSB first, one per 16 ticks -> PARITY if enabled, else STOP.
//   - PARITY: sample parity bit -> STOP.
//   - STOP: at mid-bit:
//     - rx=1: byte pushed (unless parity failed) -> IDLE.
//     - rx=0: frame_err pulse, byte discarded -> BREAK.
//   - BREAK: wait for synced rx=1 -> IDLE.
// - Latency: data_valid rises 1 clk after the mid-stop sample (empty FIFO).
// - FIFO:
//   - Show-ahead: data_out = mem[rd_ptr] combinationally.
//   - Pop when rd_en && data_valid.
// - FIFO boundaries:
//   - Push with count=FIFO_DEPTH and no pop: byte dropped, overrun <= 1 until rst.
//   - Push and pop same clk when full: both accepted, count unchanged, no overrun.
//   - Push and pop same clk when count=1: count stays 1, data_out = new byte next clk.
//   - Pop when empty: ignored, count stays 0.
//   - Pointers wrap modulo FIFO_DEPTH.
// - Error pulses never coincide with a push of the same frame.
// CONFIGURATION
// - Macro UART_RX_PARITY_EN.
// - Defined:
//   - PARITY state present; even parity over the data bits.
//   - Mismatch: parity_err pulse 1 clk at the mid-stop sample, byte not pushed.
//   - Stop bit is still checked; a frame error also asserts frame_err.
// - Undefined: PARITY state absent, frame is 8N1, parity_err tied 0.
// TESTING
// - CLK_FREQ=50e6, BAUD=115200 (432 clk/bit) unless noted.
// - 1. Send 0x24 -> data_valid=1, data_out=0x24, fifo_count=1 one clk after mid-stop;
//   rd_en 1 clk -> count 0.
// - 2. Send 0x41,0x24,0x42 without reading -> count 3, popped in order 0x41,0x24,0x42.
// - 3. Send 5 bytes 0x01..0x05, no reads -> count 4, overrun=1, pops give 0x01..0x04.
// - 4. rx low pulse of 100 clk -> no push, no frame_err, FSM back to IDLE.
// - 5. Send 0x55 with stop bit forced low ->
//   frame_err 1-clk pulse, count 0; next valid 0x33 accepted once rx returns high.
// - 6. With UART_RX_PARITY_EN, send 0x07 with parity bit 0 ->
//   parity_err pulse, count 0; parity bit 1 -> 0x07 pushed.
// - 7. Assert rst mid-DATA of 0x5A -> outputs 0, count 0; the next full frame is received correctly.

Source files
------------

// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver (even parity frame with `UART_RX_PARITY_EN) feeding a show-ahead byte FIFO.
// Latency: data_valid 1 clk after mid-stop sample; no line backpressure, full FIFO drops byte and sets overrun.
module uart_byte_receiver #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    input  logic                          rd_en,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          data_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun
);
    localparam int DIV   = CLK_FREQ / (16 * BAUD);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int BW    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [BW-1:0]    BIT_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [AW:0]      FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif

    logic                  rx_meta_q, rx_sync_q;
    logic [2:0]            state_q, state_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [3:0]            samp_q, samp_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  frame_err_q, frame_err_d;
    logic                  push_req, tick, mid;
    logic                  par_ok;
`ifdef UART_RX_PARITY_EN
    logic                  par_q, par_d;
    logic                  parity_err_q, parity_err_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    assign tick = (div_q == DIV_LAST);
    // samp_q free-runs across bits, so every bit is sampled when it reads 7
    assign mid  = tick && (samp_q == 4'd7);
`ifdef UART_RX_PARITY_EN
    assign par_ok = ((^shift_q) == par_q);
`else
    assign par_ok = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        div_d       = tick ? '0 : div_q + 1'b1;
        samp_d      = tick ? samp_q + 4'd1 : samp_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        push_req    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rx_sync_q) begin
                    state_d = S_START;
                    div_d   = '0;
                    samp_d  = '0;
                end
            end
            S_START: begin
                if (mid) begin
                    state_d = rx_sync_q ? S_IDLE : S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (mid) begin
                    shift_d = {rx_sync_q, shift_q[DATA_WIDTH-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (mid) begin
                    par_d   = rx_sync_q;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (mid) begin
`ifdef UART_RX_PARITY_EN
                    parity_err_d = !par_ok;
`endif
                    if (rx_sync_q) begin
                        push_req = par_ok;
                        state_d  = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rx_sync_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            samp_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            samp_q      <= samp_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [AW:0]           count_q;
    logic                  overrun_q;
    logic                  full, pop, push;

    assign full = (count_q == FULL_CNT);
    assign pop  = rd_en && (count_q != '0);
    // A simultaneous pop frees the slot, so a full FIFO still accepts the byte
    assign push = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= shift_q;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (push_req && full && !pop) overrun_q <= 1'b1;
        end
    end

    assign data_out   = mem_q[rd_ptr_q];
    assign data_valid = (count_q != '0);
    assign fifo_count = count_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Directed bench for uart_byte_receiver at 50 MHz / 115200 baud (432 clk per bit).
module tb_uart_byte_receiver;
    localparam int BIT_CLK = 432;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, rx, rd_en;
    logic [7:0] data_out;
    logic       data_valid;
    logic [2:0] fifo_count;
    logic       frame_err, parity_err, overrun;

    int checks = 0, passed = 0;
    int ferr_cnt = 0, perr_cnt = 0;
    logic [7:0] exp_q[$];
    logic       exp_ovr = 1'b0;

    always #10 clk = ~clk;

    uart_byte_receiver dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rd_en      (rd_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    // Each high cycle is counted, so a pulse wider than 1 clk shows up as an extra count
    always @(negedge clk) begin
        if (frame_err === 1'b1)  ferr_cnt++;
        if (parity_err === 1'b1) perr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit bad_par);
        if (stop_ok && !(PAR_EN && bad_par)) begin
            if (exp_q.size() < 4) exp_q.push_back(b);
            else exp_ovr = 1'b1;
        end
        @(negedge clk);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        if (PAR_EN) drive_bit((^b) ^ bad_par);
        drive_bit(stop_ok);
        if (!stop_ok) drive_bit(1'b0);
        rx = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        @(negedge clk);
        check({tag, " valid"}, {31'd0, data_valid}, 32'd1);
        if (exp_q.size() == 0) begin
            checks++;
            $error("FAIL %s: got %0h expected nothing queued", tag, data_out);
        end else begin
            e = exp_q.pop_front();
            check(tag, {24'd0, data_out}, {24'd0, e});
        end
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, f0, p0;
        rst = 1'b1; rx = 1'b1; rd_en = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        check("rst data_valid", {31'd0, data_valid}, 32'd0);
        check("rst fifo_count", {29'd0, fifo_count}, 32'd0);
        check("rst frame_err",  {31'd0, frame_err},  32'd0);
        check("rst parity_err", {31'd0, parity_err}, 32'd0);
        check("rst overrun",    {31'd0, overrun},    32'd0);
        repeat (10) @(negedge clk);

        // Start-bit edge to data_valid: ~9.5 bit times plus synchroniser and decision delay
        n = 0;
        fork
            send_frame(8'h24, 1'b1, 1'b0);
            begin
                @(negedge clk);
                while (data_valid !== 1'b1 && n < 5000) begin
                    @(posedge clk); #1; n++;
                end
            end
        join
        check("t1 latency window", {31'd0, (n >= 4100 && n <= 4114)}, 32'd1);
        check("t1 count", {29'd0, fifo_count}, 32'd1);
        pop_check("t1 byte");
        check("t1 count after pop", {29'd0, fifo_count}, 32'd0);
        rd_en = 1'b1; @(negedge clk); rd_en = 1'b0; @(negedge clk);
        check("pop empty count", {29'd0, fifo_count}, 32'd0);
        check("pop empty valid", {31'd0, data_valid}, 32'd0);

        send_frame(8'h41, 1'b1, 1'b0);
        send_frame(8'h24, 1'b1, 1'b0);
        send_frame(8'h42, 1'b1, 1'b0);
        check("t2 count", {29'd0, fifo_count}, 32'd3);
        pop_check("t2 byte0");
        pop_check("t2 byte1");
        pop_check("t2 byte2");
        check("t2 count after pops", {29'd0, fifo_count}, 32'd0);

        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
        check("t3 count", {29'd0, fifo_count}, 32'd4);
        check("t3 overrun", {31'd0, overrun}, {31'd0, exp_ovr});
        for (int i = 0; i < 4; i++) pop_check("t3 byte");
        check("t3 count after pops", {29'd0, fifo_count}, 32'd0);

        f0 = ferr_cnt;
        @(negedge clk); rx = 1'b0;
        repeat (100) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        check("t4 glitch count", {29'd0, fifo_count}, 32'd0);
        check("t4 glitch frame_err", ferr_cnt - f0, 32'd0);
        send_frame(8'hA5, 1'b1, 1'b0);
        pop_check("t4 byte after glitch");

        f0 = ferr_cnt;
        send_frame(8'h55, 1'b0, 1'b0);
        check("t5 frame_err pulses", ferr_cnt - f0, 32'd1);
        check("t5 count", {29'd0, fifo_count}, 32'd0);
        send_frame(8'h33, 1'b1, 1'b0);
        check("t5 count after good", {29'd0, fifo_count}, 32'd1);
        pop_check("t5 byte after break");

`ifdef UART_RX_PARITY_EN
        p0 = perr_cnt;
        send_frame(8'h07, 1'b1, 1'b1);
        check("t6 parity_err pulses", perr_cnt - p0, 32'd1);
        check("t6 count", {29'd0, fifo_count}, 32'd0);
        send_frame(8'h07, 1'b1, 1'b0);
        check("t6 no new parity_err", perr_cnt - p0, 32'd1);
        pop_check("t6 byte good parity");
`else
        p0 = 0;
        check("t6 parity_err never", perr_cnt - p0, 32'd0);
`endif

        check("t7 overrun sticky", {31'd0, overrun}, 32'd1);
        f0 = ferr_cnt;
        @(negedge clk);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        rst = 1'b1; rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_ovr = 1'b0;
        check("t7 rst valid",   {31'd0, data_valid}, 32'd0);
        check("t7 rst count",   {29'd0, fifo_count}, 32'd0);
        check("t7 rst overrun", {31'd0, overrun},    {31'd0, exp_ovr});
        check("t7 rst frame_err", {31'd0, frame_err}, 32'd0);
        repeat (2 * BIT_CLK) @(negedge clk);
        check("t7 no partial push", {29'd0, fifo_count}, 32'd0);
        send_frame(8'h5A, 1'b1, 1'b0);
        check("t7 count", {29'd0, fifo_count}, 32'd1);
        pop_check("t7 byte after rst");
        check("t7 no frame_err", ferr_cnt - f0, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
